// File: rtl/adding_machine_sequencer.sv
// adding_machine_sequencer: walks a word-indexed memory from a programmed base
// index for a programmed number of words, registering each word once before
// adding it into a 32-bit accumulator. Provides a start/busy/done handshake,
// a stall input and a sticky overflow flag.
// Optional feature: define ADDSEQ_SATURATE_EN to saturate the accumulator at
// 0xFFFFFFFF on carry-out instead of wrapping modulo 2^32.
module adding_machine_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [29:0]      base_index,
  input  logic [LEN_W-1:0] length,
  input  logic             stall,
  output logic [29:0]      mem_index,
  input  logic [31:0]      mem_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sum,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [29:0]      idx;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      data_p1;
  logic             vld_p1;
  logic [32:0]      acc_next;

  // 33-bit add; bit 32 is the carry-out. With saturation enabled a carry
  // pins the result at all-ones, and since any later nonzero add carries
  // again (and a zero add leaves it unchanged) the sum stays pinned.
  function automatic logic [32:0] acc_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = {1'b0, a} + {1'b0, b};
`ifdef ADDSEQ_SATURATE_EN
    if (r[32]) r[31:0] = 32'hFFFF_FFFF;
`endif
    return r;
  endfunction

  // Accumulator candidate: current sum plus the registered word
  always_comb begin
    acc_next = acc_add(sum, data_p1);
  end

  assign mem_index = idx;
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE);

  // Sequencer: fetch stage feeds data_p1, accumulate stage consumes it
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      remaining <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum      <= '0;
            overflow <= 1'b0;
            if (length != '0) begin
              state     <= FETCH;
              idx       <= base_index;
              remaining <= length;
              vld_p1    <= 1'b0;
            end else begin
              state <= DONE;
            end
          end
        end
        FETCH: begin
          if (!stall) begin
            data_p1   <= mem_data;
            vld_p1    <= 1'b1;
            idx       <= idx + 30'd1;
            remaining <= remaining - LEN_W'(1);
            if (vld_p1) begin
              sum      <= acc_next[31:0];
              overflow <= overflow | acc_next[32];
            end
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stall) begin
            sum      <= acc_next[31:0];
            overflow <= overflow | acc_next[32];
            vld_p1   <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adding_machine_sequencer.sv
// Directed testbench for adding_machine_sequencer. The bench memory returns
// mem[i] = i+1, or a two-word overflow pattern when ovmode is set.
module tb_adding_machine_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [29:0] base_index;
  logic [15:0] length;
  logic        stall;
  logic [29:0] mem_index;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        overflow;
  logic        ovmode;

  int checks   = 0;
  int failures = 0;

  adding_machine_sequencer #(.LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_index (base_index),
    .length     (length),
    .stall      (stall),
    .mem_index  (mem_index),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Combinational bench memory
  always_comb begin
    mem_data = {2'b00, mem_index} + 32'd1;
    if (ovmode) begin
      if (mem_index == 30'd0)      mem_data = 32'hFFFF_FFFF;
      else if (mem_index == 30'd1) mem_data = 32'h0000_0002;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One run: start at a negedge, then observe at every following negedge.
  // cyc=k shows the state after edge E(k-1), E0 being the start edge.
  task automatic run(input string tag, input logic [29:0] b, input logic [15:0] n,
                     input int st_at, input int st_n, input int ign_at,
                     input logic [31:0] esum, input logic eovf,
                     input int edone, input int ebusy);
    int          cyc;
    int          nb;
    int          dcyc;
    bit          got;
    bit          pst;
    logic [29:0] pidx;
    logic [29:0] nidx;
    logic [31:0] psum;
    nb = 0; dcyc = 0; got = 0; pst = 0; pidx = '0; psum = '0;
    nidx = b + 30'd1;
    @(negedge clk);
    base_index = b; length = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= 40 && !got) begin
      if (pst) begin
        chk({tag, "_stall_idx"}, {2'b00, mem_index}, {2'b00, pidx});
        chk({tag, "_stall_sum"}, sum, psum);
      end
      if (cyc == 1 && n != 16'd0) chk({tag, "_idx0"}, {2'b00, mem_index}, {2'b00, b});
      if (cyc == 2 && n >= 16'd2) chk({tag, "_idx1"}, {2'b00, mem_index}, {2'b00, nidx});
      if (busy) nb++;
      if (done) begin
        got = 1; dcyc = cyc;
      end else begin
        pidx  = mem_index;
        psum  = sum;
        pst   = (cyc >= st_at) && (cyc < st_at + st_n);
        stall = pst;
        start = (cyc == ign_at);
        if (cyc == ign_at) length = 16'd0;
        @(negedge clk);
        cyc++;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    chk({tag, "_done_cyc"}, dcyc, edone);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
    chk({tag, "_busy_cycles"}, nb, ebusy);
    // start in the DONE cycle must be ignored
    length = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum_hold"}, sum, esum);
  endtask

  initial begin
    int dhits;
    reset = 1'b1; start = 1'b0; stall = 1'b0; base_index = '0; length = '0; ovmode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_idx", {2'b00, mem_index}, 32'd0);
    reset = 1'b0;

    run("basic", 30'd0, 16'd4, 0, 0, 0, 32'd10, 1'b0, 6, 5);
    run("len0", 30'd5, 16'd0, 0, 0, 0, 32'd0, 1'b0, 1, 0);
    run("stall", 30'd2, 16'd3, 2, 2, 0, 32'd12, 1'b0, 7, 6);

    ovmode = 1'b1;
`ifdef ADDSEQ_SATURATE_EN
    run("ovf", 30'd0, 16'd2, 0, 0, 0, 32'hFFFF_FFFF, 1'b1, 4, 3);
`else
    run("ovf", 30'd0, 16'd2, 0, 0, 0, 32'h0000_0001, 1'b1, 4, 3);
`endif
    ovmode = 1'b0;
    run("wrap", 30'h3FFF_FFFF, 16'd2, 0, 0, 0, 32'h4000_0001, 1'b0, 4, 3);

    // Reset two cycles into a length-8 run
    @(negedge clk);
    base_index = 30'd0; length = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", sum, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_idx", {2'b00, mem_index}, 32'd0);
    dhits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dhits++;
    end
    chk("abort_no_done", dhits, 0);

    run("post_rst_ign", 30'd0, 16'd4, 0, 0, 2, 32'd10, 1'b0, 6, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
